// File: rtl/dp_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dp_share_arbiter
// Brief    : Round-robin sharing of one fixed-latency, non-stallable datapath
//            among NREQ requesters; a tag pipeline routes results back.
// Revision : 1.0 - initial release
// ============================================================================
module dp_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int LATENCY = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    drain,
  output logic [WIDTH-1:0]        dp_in,
  input  logic [WIDTH-1:0]        dp_out,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    busy
);

  localparam int              c_IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [c_IW-1:0] c_LAST_RST = c_IW'(NREQ - 1);

  logic [c_IW-1:0]  r_last;
  logic [WIDTH-1:0] r_dp_in;
  logic [NREQ-1:0]  r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic [LATENCY:0] r_tag_v;
  logic [c_IW-1:0]  r_tag_idx [LATENCY+1];

  logic [WIDTH-1:0] w_words [NREQ];
  logic [c_IW-1:0]  w_gnt_idx;
  logic [c_IW-1:0]  w_try;
  int               w_sum;
  logic             w_gnt_any;
  logic [NREQ-1:0]  w_ready;
  logic             w_xfer;
  logic [NREQ-1:0]  w_rsp_onehot;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_words[i] = req_data[i*WIDTH +: WIDTH];
  end

  // Search starts one past the last winner and wraps modulo NREQ.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_try     = '0;
    w_sum     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_sum = int'(r_last) + k;
      if (w_sum >= NREQ) w_sum = w_sum - NREQ;
      w_try = c_IW'(w_sum);
      if (!w_gnt_any && req_valid[w_try]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_try;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (rst && !drain && w_gnt_any) w_ready[w_gnt_idx] = 1'b1;
  end

  assign w_xfer    = |(req_valid & w_ready);
  assign req_ready = w_ready;

  always_comb begin
    w_rsp_onehot = '0;
    w_rsp_onehot[r_tag_idx[LATENCY]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last      <= c_LAST_RST;
      r_dp_in     <= '0;
      r_tag_v     <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      for (int s = 0; s <= LATENCY; s++) r_tag_idx[s] <= '0;
    end else begin
      // The tag pipe free-runs because the datapath itself cannot stall.
      r_tag_v      <= {r_tag_v[LATENCY-1:0], w_xfer};
      r_tag_idx[0] <= w_gnt_idx;
      for (int s = 1; s <= LATENCY; s++) r_tag_idx[s] <= r_tag_idx[s-1];
      if (w_xfer) begin
        r_dp_in <= w_words[w_gnt_idx];
        r_last  <= w_gnt_idx;
      end
      r_rsp_valid <= '0;
      if (r_tag_v[LATENCY]) begin
        r_rsp_valid <= w_rsp_onehot;
        r_rsp_data  <= dp_out;
      end
    end
  end

  assign dp_in     = r_dp_in;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = |r_tag_v;

endmodule
`default_nettype wire

// File: tb/tb_dp_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_share_arbiter
// Brief    : Scenario bench for dp_share_arbiter against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dp_share_arbiter;
  localparam int WIDTH = 32, NREQ = 4, LATENCY = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid, req_ready, rsp_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  drain, busy;
  logic [WIDTH-1:0]      dp_in, dp_out, rsp_data;
  logic [WIDTH-1:0]      dp_d1, dp_d2, dp_d3;

  dp_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .drain(drain), .dp_in(dp_in), .dp_out(dp_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared core stand-in: inverts its input, three cycles of latency.
  always @(posedge clk) begin
    dp_d1 <= ~dp_in;
    dp_d2 <= dp_d1;
    dp_d3 <= dp_d2;
  end
  assign dp_out = dp_d3;

  typedef struct { int hs; int idx; logic [WIDTH-1:0] data; } ent_t;
  ent_t             q[$];
  int               m_cycle, m_last, checks, errors;
  logic [WIDTH-1:0] m_dp_in, m_rsp_data;
  logic [NREQ-1:0]  m_rsp_valid;
  logic             m_busy, next_rst;
  logic [WIDTH-1:0] words [NREQ];
  bit               regen [NREQ];

  function automatic int pick(input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int g = pick(req_valid);
    if (!rst || drain || g < 0) return '0;
    return NREQ'(1) << g;
  endfunction

  task automatic model_reset();
    q.delete();
    m_last = NREQ - 1; m_dp_in = '0; m_rsp_data = '0; m_rsp_valid = '0; m_busy = 1'b0;
  endtask

  task automatic drive(input logic [NREQ-1:0] v, input logic dr);
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (regen[i]) begin words[i] = $urandom; regen[i] = 0; end
      req_data[i*WIDTH +: WIDTH] = words[i];
    end
    req_valid = v; drain = dr; rst = next_rst;
    if (!next_rst) model_reset();
    #1;
  endtask

  // Advance the model across one rising edge.
  task automatic advance();
    int g;
    g = pick(req_valid);
    @(posedge clk);
    m_cycle++;
    if (rst) begin
      if (!drain && g >= 0) begin
        q.push_back('{m_cycle - 1, g, ~words[g]});
        m_last = g; m_dp_in = words[g]; regen[g] = 1;
      end
      m_rsp_valid = '0;
      if (q.size() > 0 && q[0].hs + LATENCY + 2 == m_cycle) begin
        m_rsp_valid = NREQ'(1) << q[0].idx;
        m_rsp_data  = q[0].data;
        void'(q.pop_front());
      end
      m_busy = 1'b0;
      foreach (q[i]) if (q[i].hs + LATENCY + 1 >= m_cycle) m_busy = 1'b1;
    end
  endtask

  task automatic test_reset();
    next_rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive('1, 1'b0);
      checks++;
      if (req_ready !== '0 || rsp_valid !== '0 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_ctl: ready=%b rsp_valid=%b busy=%b want 0000/0000/0", req_ready, rsp_valid, busy);
      end
      checks++;
      if (dp_in !== '0 || rsp_data !== '0) begin
        errors++; $display("FAIL reset_data: dp_in=%h rsp_data=%h want 0/0", dp_in, rsp_data);
      end
      advance();
    end
    next_rst = 1'b1;
    drive('1, 1'b0);
    checks++;
    if (req_ready !== 4'b0001 || req_ready !== exp_ready()) begin
      errors++; $display("FAIL reset_first_grant: ready=%b want 0001", req_ready);
    end
    advance();
    for (int k = 0; k < 7; k++) begin
      drive('0, 1'b0);
      checks++;
      if (rsp_valid !== m_rsp_valid || rsp_data !== m_rsp_data || busy !== m_busy) begin
        errors++; $display("FAIL reset_flush: rsp=%b/%h busy=%b want %b/%h/%b", rsp_valid, rsp_data, busy, m_rsp_valid, m_rsp_data, m_busy);
      end
      advance();
    end
  endtask

  task automatic test_single();
    regen[2] = 0; words[2] = 32'habcdefab;
    drive(4'b0100, 1'b0);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_grant: ready=%b want 0100", req_ready);
    end
    advance();
    for (int k = 1; k <= 6; k++) begin
      drive('0, 1'b0);
      checks++;
      if (busy !== (k <= 4) || busy !== m_busy) begin
        errors++; $display("FAIL single_busy: c+%0d busy=%b want %b", k, busy, (k <= 4));
      end
      checks++;
      if (rsp_valid !== (k == 5 ? 4'b0100 : 4'b0000) || (k == 5 && rsp_data !== 32'h54321054)) begin
        errors++; $display("FAIL single_rsp: c+%0d rsp=%b/%h want %b/54321054", k, rsp_valid, rsp_data, (k == 5 ? 4'b0100 : 4'b0000));
      end
      advance();
    end
  endtask

  task automatic test_round_robin();
    int first;
    first = (m_last + 1) % NREQ;
    for (int k = 0; k < 12; k++) begin
      drive('1, 1'b0);
      checks++;
      if (req_ready !== exp_ready() || req_ready !== (NREQ'(1) << ((first + k) % NREQ))) begin
        errors++; $display("FAIL rr_grant: k=%0d ready=%b want %b", k, req_ready, NREQ'(1) << ((first + k) % NREQ));
      end
      checks++;
      if (rsp_valid !== m_rsp_valid || rsp_data !== m_rsp_data || dp_in !== m_dp_in) begin
        errors++; $display("FAIL rr_rsp: rsp=%b/%h dp_in=%h want %b/%h/%h", rsp_valid, rsp_data, dp_in, m_rsp_valid, m_rsp_data, m_dp_in);
      end
      advance();
    end
    for (int k = 0; k < 7; k++) begin
      drive('0, 1'b0);
      checks++;
      if (rsp_valid !== m_rsp_valid || rsp_data !== m_rsp_data || busy !== m_busy) begin
        errors++; $display("FAIL rr_flush: rsp=%b/%h busy=%b want %b/%h/%b", rsp_valid, rsp_data, busy, m_rsp_valid, m_rsp_data, m_busy);
      end
      advance();
    end
  endtask

  task automatic test_sparse_wrap();
    drive(4'b1000, 1'b0);
    advance();
    for (int k = 0; k < 4; k++) begin
      drive(4'b1010, 1'b0);
      checks++;
      if (req_ready !== ((k % 2 == 0) ? 4'b0010 : 4'b1000) || req_ready !== exp_ready()) begin
        errors++; $display("FAIL sparse_grant: k=%0d ready=%b want %b", k, req_ready, (k % 2 == 0) ? 4'b0010 : 4'b1000);
      end
      advance();
    end
    for (int k = 0; k < 7; k++) begin
      drive('0, 1'b0);
      checks++;
      if (rsp_valid !== m_rsp_valid || rsp_data !== m_rsp_data || busy !== m_busy) begin
        errors++; $display("FAIL sparse_flush: rsp=%b/%h busy=%b want %b/%h/%b", rsp_valid, rsp_data, busy, m_rsp_valid, m_rsp_data, m_busy);
      end
      advance();
    end
  endtask

  task automatic test_drain();
    int n_rsp, resume;
    n_rsp = 0;
    for (int k = 0; k < 3; k++) begin
      drive('1, 1'b0);
      checks++;
      if (req_ready !== exp_ready()) begin
        errors++; $display("FAIL drain_fill: ready=%b want %b", req_ready, exp_ready());
      end
      advance();
    end
    resume = (m_last + 1) % NREQ;
    for (int k = 0; k < 8; k++) begin
      drive('1, 1'b1);
      checks++;
      if (req_ready !== '0) begin
        errors++; $display("FAIL drain_ready: ready=%b want 0000", req_ready);
      end
      checks++;
      if (busy !== (k < 4) || rsp_valid !== m_rsp_valid || rsp_data !== m_rsp_data) begin
        errors++; $display("FAIL drain_pipe: k=%0d busy=%b rsp=%b/%h want %b/%b/%h", k, busy, rsp_valid, rsp_data, (k < 4), m_rsp_valid, m_rsp_data);
      end
      if (rsp_valid != 0) n_rsp++;
      advance();
    end
    checks++;
    if (n_rsp !== 3) begin
      errors++; $display("FAIL drain_count: responses=%0d want 3", n_rsp);
    end
    drive('1, 1'b0);
    checks++;
    if (req_ready !== (NREQ'(1) << resume)) begin
      errors++; $display("FAIL drain_resume: ready=%b want %b", req_ready, NREQ'(1) << resume);
    end
    advance();
    for (int k = 0; k < 7; k++) begin
      drive('0, 1'b0);
      checks++;
      if (rsp_valid !== m_rsp_valid || rsp_data !== m_rsp_data || busy !== m_busy) begin
        errors++; $display("FAIL drain_flush: rsp=%b/%h busy=%b want %b/%h/%b", rsp_valid, rsp_data, busy, m_rsp_valid, m_rsp_data, m_busy);
      end
      advance();
    end
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 4; k++) begin
      drive('1, 1'b0);
      advance();
    end
    next_rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive('1, 1'b0);
      checks++;
      if (req_ready !== '0 || rsp_valid !== '0 || busy !== 1'b0 || dp_in !== '0) begin
        errors++; $display("FAIL midrst_hold: ready=%b rsp=%b busy=%b dp_in=%h want all zero", req_ready, rsp_valid, busy, dp_in);
      end
      advance();
    end
    next_rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive('0, 1'b0);
      checks++;
      if (rsp_valid !== '0 || busy !== 1'b0) begin
        errors++; $display("FAIL midrst_stale: rsp=%b busy=%b want 0000/0", rsp_valid, busy);
      end
      advance();
    end
    drive('1, 1'b0);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL midrst_grant: ready=%b want 0001", req_ready);
    end
    advance();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] pend, got;
    logic            dr;
    pend = '0;
    for (int k = 0; k < 80; k++) begin
      pend = pend | NREQ'($urandom_range(0, 15));
      dr   = ($urandom_range(0, 7) == 0);
      drive(pend, dr);
      checks++;
      if (req_ready !== exp_ready()) begin
        errors++; $display("FAIL rand_grant: k=%0d ready=%b want %b", k, req_ready, exp_ready());
      end
      checks++;
      if (rsp_valid !== m_rsp_valid || rsp_data !== m_rsp_data || busy !== m_busy || dp_in !== m_dp_in) begin
        errors++; $display("FAIL rand_out: k=%0d rsp=%b/%h busy=%b dp_in=%h want %b/%h/%b/%h", k, rsp_valid, rsp_data, busy, dp_in, m_rsp_valid, m_rsp_data, m_busy, m_dp_in);
      end
      got = req_ready;
      advance();
      pend = pend & ~got;
    end
    for (int k = 0; k < 7; k++) begin
      drive('0, 1'b0);
      checks++;
      if (rsp_valid !== m_rsp_valid || rsp_data !== m_rsp_data || busy !== m_busy) begin
        errors++; $display("FAIL rand_flush: rsp=%b/%h busy=%b want %b/%h/%b", rsp_valid, rsp_data, busy, m_rsp_valid, m_rsp_data, m_busy);
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b0; next_rst = 1'b0; req_valid = '0; drain = 1'b0; req_data = '0;
    checks = 0; errors = 0; m_cycle = 0;
    for (int i = 0; i < NREQ; i++) begin
      words[i] = $urandom;
      regen[i] = 0;
    end
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_sparse_wrap();
    test_drain();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
